// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the core pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] src_a;
   logic [DATA_WIDTH-1:0] src_b;
   logic                  flush;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take DATA_WIDTH step cycles plus one fix-up cycle;
// MTHI/MTLO write in the cycle they are requested.
//
// state  | meaning
// S_IDLE | waiting for a request; MTHI/MTLO handled here
// S_MUL  | shift-add step on the operand magnitudes, one bit per cycle
// S_DIV  | restoring divide step on the operand magnitudes, one bit per cycle
// S_FIX  | apply signs / divide-by-zero result, write HI/LO, pulse done
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;
   logic [W-1:0]    r_hi;
   logic [W-1:0]    r_lo;
   logic [W-1:0]    r_m;        // multiplicand (MUL) or divisor (DIV) magnitude
   logic [W-1:0]    r_acc;      // product high half / partial remainder
   logic [W-1:0]    r_q;        // multiplier bits / dividend bits -> product low half / quotient
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_div;
   logic            r_div0;
   logic [W-1:0]    r_orig_a;

   logic            w_is_mul;
   logic            w_is_div;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [W-1:0]    w_a_mag;
   logic [W-1:0]    w_b_mag;
   logic [W:0]      w_mul_sum;
   logic [W:0]      w_div_shift;
   logic            w_div_ge;
   logic [W-1:0]    w_div_diff;
   logic [2*W-1:0]  w_prod;
   logic [2*W-1:0]  w_prod_fix;
   logic [W-1:0]    w_quo;
   logic [W-1:0]    w_rem;

   assign w_is_mul = ~bus.op[2] & ~bus.op[1];
   assign w_is_div = ~bus.op[2] &  bus.op[1];
   assign w_signed = ~bus.op[0];
   assign w_a_neg  = w_signed & bus.src_a[W-1];
   assign w_b_neg  = w_signed & bus.src_b[W-1];
   // The most-negative value maps to itself, which is its correct unsigned magnitude.
   assign w_a_mag  = w_a_neg ? -bus.src_a : bus.src_a;
   assign w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;

   assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
   assign w_div_shift = {r_acc, r_q[W-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
   assign w_div_diff  = w_div_shift[W-1:0] - r_m;

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo      = r_neg_q ? -r_q : r_q;
   assign w_rem      = r_neg_r ? -r_acc : r_acc;

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

   // Sequencer: request acceptance, per-bit iteration, result write-back; flush aborts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_m      <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_orig_a <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     if (w_is_mul || w_is_div) begin
                        r_state  <= w_is_mul ? S_MUL : S_DIV;
                        r_busy   <= 1'b1;
                        r_cnt    <= CW'(W - 1);
                        r_m      <= w_is_mul ? w_a_mag : w_b_mag;
                        r_q      <= w_is_mul ? w_b_mag : w_a_mag;
                        r_acc    <= '0;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_is_div <= w_is_div;
                        r_div0   <= (bus.src_b == '0);
                        r_orig_a <= bus.src_a;
                     end else if (bus.op == 3'b100) begin
                        r_hi <= bus.src_a;
                     end else if (bus.op == 3'b101) begin
                        r_lo <= bus.src_a;
                     end
                  end
               end
               S_MUL: begin
                  r_acc <= w_mul_sum[W:1];
                  r_q   <= {w_mul_sum[0], r_q[W-1:1]};
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0) r_state <= S_FIX;
               end
               S_DIV: begin
                  r_acc <= w_div_ge ? w_div_diff : w_div_shift[W-1:0];
                  r_q   <= {r_q[W-2:0], w_div_ge};
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0) r_state <= S_FIX;
               end
               S_FIX: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  if (!r_is_div) begin
                     {r_hi, r_lo} <= w_prod_fix;
                  end else if (r_div0) begin
                     r_hi <= r_orig_a;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
